// File: rtl/svm_ovo_seq_classifier_pkg.sv
// Shared types and helpers for the sequential one-vs-one SVM classifier.
// Pair enumeration is lexicographic: (0,1), (0,2), ..., (N_CLASS-2, N_CLASS-1).
package svm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        VOTE = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SAT_CALC_W = 32;

    function automatic int n_pair(input int n_class);
        return n_class * (n_class - 1) / 2;
    endfunction

    function automatic int pair_i(input int p, input int n_class);
        int k;
        int r;
        k = 0;
        r = 0;
        for (int i = 0; i < n_class; i++) begin
            for (int j = i + 1; j < n_class; j++) begin
                if (k == p) r = i;
                k = k + 1;
            end
        end
        return r;
    endfunction

    function automatic int pair_j(input int p, input int n_class);
        int k;
        int r;
        k = 0;
        r = 0;
        for (int i = 0; i < n_class; i++) begin
            for (int j = i + 1; j < n_class; j++) begin
                if (k == p) r = j;
                k = k + 1;
            end
        end
        return r;
    endfunction

    // Clamp a wide signed sum into the signed range of an acc_w-bit accumulator.
    function automatic logic signed [SAT_CALC_W-1:0] sat_clip(
        input logic signed [SAT_CALC_W-1:0] v,
        input int                           acc_w
    );
        logic signed [SAT_CALC_W-1:0] hi;
        logic signed [SAT_CALC_W-1:0] lo;
        hi = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (acc_w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/svm_ovo_seq_classifier_pair_mac.sv
// One pair's accumulator: loads the intercept, then adds one weight*feature per cycle.
// Wraps modulo 2^ACC_W by default; saturates when SVM_ACC_SAT_EN is defined.
module svm_pair_mac
    import svm_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int W_W   = 8,
    parameter int ACC_W = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_en,
    input  logic signed [ACC_W-1:0] i_bias,
    input  logic signed [W_W-1:0]   i_weight,
    input  logic [IN_W-1:0]         i_feat,
    output logic                    o_neg
);
    localparam int PROD_W = W_W + IN_W + 1;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_next;
    logic signed [ACC_W-1:0]  w_load_val;
    logic signed [ACC_W-1:0]  r_acc;

    // Features are unsigned, so a zero MSB keeps the multiply signed-correct.
    assign w_prod = i_weight * $signed({1'b0, i_feat});

`ifdef SVM_ACC_SAT_EN
    logic signed [SAT_CALC_W-1:0] w_sum;
    assign w_sum      = SAT_CALC_W'(r_acc) + SAT_CALC_W'(w_prod);
    assign w_next     = ACC_W'(sat_clip(w_sum, ACC_W));
    assign w_load_val = ACC_W'(sat_clip(SAT_CALC_W'(i_bias), ACC_W));
`else
    assign w_next     = r_acc + ACC_W'(w_prod);
    assign w_load_val = i_bias;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_acc <= '0;
        else if (i_load) r_acc <= w_load_val;
        else if (i_en)   r_acc <= w_next;
    end

    assign o_neg = r_acc[ACC_W-1];

endmodule

// File: rtl/svm_ovo_seq_classifier.sv
// Sequential one-vs-one linear SVM: one feature per cycle, all pairs in parallel, then vote/argmax.
// Optional build macro SVM_ACC_SAT_EN selects saturating accumulation instead of wrap-around.
module svm_ovo_seq_classifier
    import svm_pkg::*;
#(
    parameter int N_FEAT  = 7,
    parameter int IN_W    = 5,
    parameter int W_W     = 8,
    parameter int ACC_W   = 13,
    parameter int N_CLASS = 3,
    parameter int CLS_W   = $clog2(N_CLASS),
    parameter int VOTE_W  = $clog2(N_CLASS)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [N_FEAT*IN_W-1:0]                        inp,
    input  logic [(N_CLASS*(N_CLASS-1)/2)*N_FEAT*W_W-1:0] w_flat,
    input  logic [(N_CLASS*(N_CLASS-1)/2)*ACC_W-1:0]      b_flat,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [CLS_W-1:0]                              out,
    output logic [N_CLASS*VOTE_W-1:0]                     predo
);
    localparam int N_PAIR = n_pair(N_CLASS);
    localparam int FIDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [FIDX_W-1:0] LAST_FIDX = FIDX_W'(N_FEAT - 1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [FIDX_W-1:0]         r_fidx;
    logic [N_FEAT*IN_W-1:0]    r_inp;
    logic [CLS_W-1:0]          r_out;
    logic [N_CLASS*VOTE_W-1:0] r_predo;

    logic                      w_load;
    logic                      w_en;
    logic                      w_vote;
    logic [IN_W-1:0]           w_feat;
    logic [N_PAIR-1:0]         w_neg;
    logic [VOTE_W-1:0]         w_cnt [N_CLASS];
    logic [VOTE_W-1:0]         w_best_cnt;
    logic [CLS_W-1:0]          w_best;
    logic [N_CLASS*VOTE_W-1:0] w_predo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_vote       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_next_state = MAC;
                end
            end
            MAC: begin
                w_en = 1'b1;
                if (r_fidx == LAST_FIDX) w_next_state = VOTE;
            end
            VOTE: begin
                w_vote       = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fidx <= '0;
            r_inp  <= '0;
        end else if (w_load) begin
            r_fidx <= '0;
            r_inp  <= inp;
        end else if (w_en) begin
            r_fidx <= (r_fidx == LAST_FIDX) ? '0 : r_fidx + FIDX_W'(1);
        end
    end

    assign w_feat = r_inp[int'(r_fidx)*IN_W +: IN_W];

    for (genvar p = 0; p < N_PAIR; p++) begin : g_pair
        logic signed [W_W-1:0] w_weight;
        assign w_weight = $signed(w_flat[(p*N_FEAT + int'(r_fidx))*W_W +: W_W]);

        svm_pair_mac #(
            .IN_W  (IN_W),
            .W_W   (W_W),
            .ACC_W (ACC_W)
        ) u_mac (
            .clk      (clk),
            .rst      (rst),
            .i_load   (w_load),
            .i_en     (w_en),
            .i_bias   ($signed(b_flat[p*ACC_W +: ACC_W])),
            .i_weight (w_weight),
            .i_feat   (w_feat),
            .o_neg    (w_neg[p])
        );
    end

    // A non-negative decision votes for the pair's first class, otherwise the second.
    always_comb begin
        for (int c = 0; c < N_CLASS; c++) w_cnt[c] = '0;
        for (int p = 0; p < N_PAIR; p++) begin
            if (w_neg[p]) w_cnt[pair_j(p, N_CLASS)] = w_cnt[pair_j(p, N_CLASS)] + VOTE_W'(1);
            else          w_cnt[pair_i(p, N_CLASS)] = w_cnt[pair_i(p, N_CLASS)] + VOTE_W'(1);
        end
    end

    // Strict comparison keeps the lowest index on ties; class 0 lands in the predo MSBs.
    always_comb begin
        w_best     = '0;
        w_best_cnt = w_cnt[0];
        w_predo    = '0;
        for (int c = 0; c < N_CLASS; c++) begin
            w_predo[(N_CLASS-1-c)*VOTE_W +: VOTE_W] = w_cnt[c];
        end
        for (int c = 1; c < N_CLASS; c++) begin
            if (w_cnt[c] > w_best_cnt) begin
                w_best     = CLS_W'(c);
                w_best_cnt = w_cnt[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_predo <= '0;
        end else if (w_vote) begin
            r_out   <= w_best;
            r_predo <= w_predo;
        end
    end

    assign out   = r_out;
    assign predo = r_predo;

endmodule
